cnt_en_ctrl: RTL and testbench
==============================

CNT_EN_CTRL -- requirements
Module: cnt_en_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port res, input, 1, reset: asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, start/restart request, sampled at posedge clk.
REQ-004 SHALL have port stop, input, 1, stop request, sampled at posedge clk.
REQ-005 SHALL have port step, input, 1, single-step request, sampled at posedge clk.
REQ-006 SHALL have port div, input, 4, prescale select; enable period = div+1 cycles.
REQ-007 SHALL have port oneshot, input, 1: 1 = auto-stop after limit+1 pulses; 0 = free-run.
REQ-008 SHALL have port limit, input, 4, pulse budget in oneshot mode (limit+1 pulses).
REQ-009 SHALL have port t, output, 1, count-enable pulse driving the T input of the downstream 4-bit sync up counter.
REQ-010 SHALL have port run, output, 1, high while in RUN.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on oneshot completion.
REQ-012 SHALL have port issued, output, 4, count of t pulses issued since last start, wraps 15->0.

Function
REQ-013 SHALL implement FSM with states IDLE, RUN, STEP; all outputs registered.
REQ-014 IDLE: t=0; prescaler held 0. start -> RUN. step with start=0 -> STEP. Otherwise stay.
REQ-015 On the start edge: prescaler cleared to 0, issued cleared to 0, div and limit latched into div_q and lim_q.
REQ-016 RUN: prescaler increments each cycle; when prescaler==div_q: t=1 for exactly one cycle, prescaler reloads 0, div_q re-latched from div. div changes therefore take effect only at a reload.
REQ-017 Latency: start sampled at edge k -> run=1 after edge k. First t high after edge k+div_q+1; subsequent t every div_q+1 cycles. With div=0, t is high on every cycle in RUN.
REQ-018 issued SHALL increment (mod 16) on each cycle t=1, in both RUN and STEP.
REQ-019 Oneshot: on the edge that issues the pulse with issued==lim_q (i.e. the (lim_q+1)-th pulse), SHALL go to IDLE at the next edge, with done=1 for that one cycle and run=0. limit=15 yields exactly 16 pulses, one full wrap of the downstream counter.
REQ-020 Free-run (oneshot=0): no auto-stop; issued wraps 15->0 silently.
REQ-021 stop in RUN -> IDLE at that edge; no further t; done stays 0. stop in IDLE or STEP is ignored.
REQ-022 start and stop on the same edge: stop wins in RUN; in IDLE, start wins (stop is ignored there).
REQ-023 start while in RUN: restart per REQ-015; stays in RUN; no t on that edge.
REQ-024 step in RUN is ignored. step and start together in IDLE: start wins.
REQ-025 STEP lasts exactly one cycle with t=1, issued+1, run=0, then -> IDLE. start or step during STEP is ignored.
REQ-026 t SHALL never be high in IDLE, and SHALL never be high for two consecutive cycles unless div_q==0.

Reset
REQ-027 res=1 SHALL immediately (asynchronously) force state IDLE, t=0, run=0, done=0, issued=0, prescaler=0, div_q=0, lim_q=0, regardless of clk.
REQ-028 Reset asserted mid-RUN SHALL abort the sequence with no done pulse. After release, the block SHALL remain in IDLE until a new start.

Verification
REQ-029 Scenario: res 1->0, div=2, oneshot=0, start pulse -> run=1; t high every 3rd cycle; issued = 1,2,3...; downstream counter q increments once per t.
REQ-030 Scenario: div=0, oneshot=1, limit=3, start -> exactly 4 consecutive t pulses, issued=4 at the end, done=1 for one cycle, then run=0.
REQ-031 Scenario: div=0, oneshot=1, limit=15, start -> 16 t pulses, downstream q wraps 15->0, issued=0, done pulse.
REQ-032 Scenario: in RUN with div=1, assert start and stop on the same edge -> IDLE, t=0 from that edge, done=0.
REQ-033 Scenario: in IDLE, 3 separate step pulses -> 3 single-cycle t pulses, issued=3, run stays 0.
REQ-034 Scenario: div=3 in RUN, assert res between clock edges -> t, run and issued are 0 before the next edge; no done pulse; IDLE after release.

Source files
------------

// File: rtl/cnt_en_ctrl.sv
// rtl/cnt_en_ctrl.sv - count-enable controller: prescaled T pulses with run/step/oneshot control
// Drives the T input of a downstream 4-bit synchronous up counter.
module cnt_en_ctrl (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic [3:0] div,
  input  logic       oneshot,
  input  logic [3:0] limit,
  output logic       t,
  output logic       run,
  output logic       done,
  output logic [3:0] issued
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t     st;
  logic [3:0] psc;
  logic [3:0] div_q;
  logic [3:0] lim_q;
  logic       last_q;

  // last_q marks that the final oneshot pulse is out; the following edge retires to IDLE with done
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      st     <= IDLE;
      psc    <= 4'd0;
      div_q  <= 4'd0;
      lim_q  <= 4'd0;
      last_q <= 1'b0;
      t      <= 1'b0;
      run    <= 1'b0;
      done   <= 1'b0;
      issued <= 4'd0;
    end else begin
      t    <= 1'b0;
      done <= 1'b0;
      case (st)
        IDLE: begin
          psc <= 4'd0;
          if (start) begin
            st     <= RUN;
            run    <= 1'b1;
            issued <= 4'd0;
            div_q  <= div;
            lim_q  <= limit;
            last_q <= 1'b0;
          end else if (step) begin
            st     <= STEP;
            t      <= 1'b1;
            issued <= issued + 4'd1;
          end
        end
        RUN: begin
          if (stop) begin
            st     <= IDLE;
            run    <= 1'b0;
            psc    <= 4'd0;
            last_q <= 1'b0;
          end else if (start) begin
            psc    <= 4'd0;
            issued <= 4'd0;
            div_q  <= div;
            lim_q  <= limit;
            last_q <= 1'b0;
          end else if (last_q) begin
            st     <= IDLE;
            run    <= 1'b0;
            done   <= 1'b1;
            psc    <= 4'd0;
            last_q <= 1'b0;
          end else if (psc == div_q) begin
            // reload point: a new div only takes effect here
            t      <= 1'b1;
            psc    <= 4'd0;
            div_q  <= div;
            issued <= issued + 4'd1;
            last_q <= oneshot && (issued == lim_q);
          end else begin
            psc <= psc + 4'd1;
          end
        end
        STEP: begin
          st <= IDLE;
        end
        default: begin
          st  <= IDLE;
          run <= 1'b0;
          psc <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_en_ctrl.sv
// tb/tb_cnt_en_ctrl.sv - self-checking bench for cnt_en_ctrl with a countdown reference model
module tb_cnt_en_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic [3:0] div = 4'd0;
  logic       oneshot = 1'b0;
  logic [3:0] limit = 4'd0;
  logic       t;
  logic       run;
  logic       done;
  logic [3:0] issued;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 run, 2 step; m_wait counts edges down to the next pulse
  int m_mode, m_wait, m_pulses, m_lim, e_q;
  bit m_fin, e_t, e_run, e_done;

  cnt_en_ctrl dut (
    .clk(clk), .res(res), .start(start), .stop(stop), .step(step),
    .div(div), .oneshot(oneshot), .limit(limit),
    .t(t), .run(run), .done(done), .issued(issued)
  );

  always #5 clk = ~clk;

  // downstream 4-bit synchronous up counter, T input driven by t
  always_ff @(posedge clk or posedge res) begin
    if (res) q <= 4'd0;
    else if (t) q <= q + 4'd1;
  end

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_pulses = 0; m_lim = 0; m_fin = 0;
    e_t = 0; e_run = 0; e_done = 0; e_q = 0;
  endtask

  task automatic tick();
    if (e_t) e_q = (e_q + 1) % 16;
    e_done = 0;
    case (m_mode)
      0: begin
        e_t = 0;
        if (start) begin
          m_mode = 1; m_wait = int'(div) + 1; m_pulses = 0; m_lim = int'(limit); m_fin = 0; e_run = 1;
        end else if (step) begin
          m_mode = 2; m_pulses++; e_t = 1;
        end
      end
      1: begin
        e_t = 0;
        if (stop) begin
          m_mode = 0; e_run = 0; m_fin = 0;
        end else if (start) begin
          m_wait = int'(div) + 1; m_pulses = 0; m_lim = int'(limit); m_fin = 0;
        end else if (m_fin) begin
          m_mode = 0; e_run = 0; e_done = 1; m_fin = 0;
        end else begin
          m_wait--;
          if (m_wait == 0) begin
            e_t = 1;
            m_pulses++;
            m_wait = int'(div) + 1;
            if (oneshot && ((m_pulses - 1) % 16) == m_lim) m_fin = 1;
          end
        end
      end
      default: begin
        e_t = 0; m_mode = 0;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    #1;
    checks += 4;
    if (t !== 1'b0) begin errors++; $display("FAIL reset_t got %b want 0", t); end
    if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", run); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (issued !== 4'd0) begin errors++; $display("FAIL reset_issued got %0d want 0", issued); end
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL reset_hold_run got %b want 0", run); end
    start = 1'b0;
    res = 1'b0;
    model_reset();
  endtask

  task automatic test_freerun_div2();
    int q0;
    div = 4'd2; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    q0 = int'(q);
    checks += 3;
    if (run !== 1'b1) begin errors++; $display("FAIL fr_run got %b want 1", run); end
    if (t !== 1'b0) begin errors++; $display("FAIL fr_t0 got %b want 0", t); end
    if (issued !== 4'd0) begin errors++; $display("FAIL fr_issued0 got %0d want 0", issued); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks += 3;
      if (t !== ((i % 3) == 0)) begin errors++; $display("FAIL fr_t cycle %0d got %b want %b", i, t, (i % 3) == 0); end
      if (int'(issued) != i / 3) begin errors++; $display("FAIL fr_issued cycle %0d got %0d want %0d", i, issued, i / 3); end
      if (int'(q) != (q0 + (i - 1) / 3) % 16) begin errors++; $display("FAIL fr_q cycle %0d got %0d want %0d", i, q, (q0 + (i - 1) / 3) % 16); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL fr_stop_run got %b want 0", run); end
  endtask

  task automatic test_oneshot(input int lim);
    int pulses, first_t, last_t, done_cyc, done_cnt, iss_at_done, run_at_done, q0, q_at_done;
    pulses = 0; first_t = -1; last_t = -1; done_cyc = -1; done_cnt = 0;
    iss_at_done = -1; run_at_done = -1; q_at_done = -1;
    div = 4'd0; oneshot = 1'b1; limit = 4'(lim); start = 1'b1;
    tick();
    start = 1'b0;
    q0 = int'(q);
    for (int i = 1; i <= lim + 10; i++) begin
      tick();
      if (t) begin
        pulses++;
        if (first_t < 0) first_t = i;
        last_t = i;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = i; iss_at_done = int'(issued); run_at_done = int'(run); q_at_done = int'(q);
        end
      end
    end
    checks += 8;
    if (pulses != lim + 1) begin errors++; $display("FAIL os%0d_pulses got %0d want %0d", lim, pulses, lim + 1); end
    if (first_t != 1) begin errors++; $display("FAIL os%0d_first got %0d want 1", lim, first_t); end
    if (last_t != lim + 1) begin errors++; $display("FAIL os%0d_last got %0d want %0d", lim, last_t, lim + 1); end
    if (done_cyc != lim + 2) begin errors++; $display("FAIL os%0d_done_cycle got %0d want %0d", lim, done_cyc, lim + 2); end
    if (done_cnt != 1) begin errors++; $display("FAIL os%0d_done_count got %0d want 1", lim, done_cnt); end
    if (iss_at_done != (lim + 1) % 16) begin errors++; $display("FAIL os%0d_issued got %0d want %0d", lim, iss_at_done, (lim + 1) % 16); end
    if (run_at_done != 0) begin errors++; $display("FAIL os%0d_run got %0d want 0", lim, run_at_done); end
    if (q_at_done != (q0 + lim + 1) % 16) begin errors++; $display("FAIL os%0d_q got %0d want %0d", lim, q_at_done, (q0 + lim + 1) % 16); end
    oneshot = 1'b0;
  endtask

  task automatic test_start_stop_same();
    div = 4'd1; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (t !== 1'b0) begin errors++; $display("FAIL ss_t cycle %0d got %b want 0", i, t); end
      if (run !== 1'b0) begin errors++; $display("FAIL ss_run cycle %0d got %b want 0", i, run); end
      if (done !== 1'b0) begin errors++; $display("FAIL ss_done cycle %0d got %b want 0", i, done); end
      tick();
    end
  endtask

  task automatic test_step();
    int tcount;
    tcount = 0;
    res = 1'b1;
    #2;
    res = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      if (t) tcount++;
      checks += 2;
      if (t !== 1'b1) begin errors++; $display("FAIL step_t pulse %0d got %b want 1", k, t); end
      if (run !== 1'b0) begin errors++; $display("FAIL step_run pulse %0d got %b want 0", k, run); end
      tick();
      if (t) tcount++;
      checks++;
      if (t !== 1'b0) begin errors++; $display("FAIL step_t_after pulse %0d got %b want 0", k, t); end
      tick();
    end
    checks += 2;
    if (tcount != 3) begin errors++; $display("FAIL step_count got %0d want 3", tcount); end
    if (issued !== 4'd3) begin errors++; $display("FAIL step_issued got %0d want 3", issued); end
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    div = 4'd3; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (issued !== 4'd1) begin errors++; $display("FAIL ar_pre_issued got %0d want 1", issued); end
    #2;
    res = 1'b1;
    #1;
    checks += 4;
    if (t !== 1'b0) begin errors++; $display("FAIL ar_t got %b want 0", t); end
    if (run !== 1'b0) begin errors++; $display("FAIL ar_run got %b want 0", run); end
    if (issued !== 4'd0) begin errors++; $display("FAIL ar_issued got %0d want 0", issued); end
    if (done !== 1'b0) begin errors++; $display("FAIL ar_done got %b want 0", done); end
    @(posedge clk);
    #1;
    res = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t || run || done) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ar_idle_after cycles_active got %0d want 0", bad); end
  endtask

  task automatic test_random();
    res = 1'b1;
    #2;
    res = 1'b0;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 24) == 0;
      stop = ($urandom % 30) == 0;
      step = ($urandom % 8) == 0;
      if (($urandom % 16) == 0) div = 4'($urandom % 16);
      else if (($urandom % 4) == 0) div = 4'($urandom % 3);
      oneshot = ($urandom % 3) != 0;
      limit = 4'($urandom % 16);
      tick();
      checks += 5;
      if (t !== e_t) begin errors++; $display("FAIL rnd_t cycle %0d got %b want %b", i, t, e_t); end
      if (run !== e_run) begin errors++; $display("FAIL rnd_run cycle %0d got %b want %b", i, run, e_run); end
      if (done !== e_done) begin errors++; $display("FAIL rnd_done cycle %0d got %b want %b", i, done, e_done); end
      if (int'(issued) != m_pulses % 16) begin errors++; $display("FAIL rnd_issued cycle %0d got %0d want %0d", i, issued, m_pulses % 16); end
      if (int'(q) != e_q) begin errors++; $display("FAIL rnd_q cycle %0d got %0d want %0d", i, q, e_q); end
    end
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_freerun_div2();
    test_oneshot(3);
    test_oneshot(15);
    test_start_stop_same();
    test_step();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
